// File: rtl/ld_st_mem_ctrl.sv
// Load/store memory controller: issues the LSQ head to a single-ported data memory,
// formats load data, and broadcasts completion on the CDB.
module ld_st_mem_ctrl #(
    parameter int ROB_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             head_valid,
    input  logic             head_st,
    input  logic [31:0]      head_addr,
    input  logic             head_addr_valid,
    input  logic [31:0]      head_wdata,
    input  logic             head_wdata_valid,
    input  logic [ROB_W-1:0] head_dest_rob,
    input  logic [2:0]       head_funct3,
    input  logic [ROB_W-1:0] rob_head,
    input  logic             flush,
    output logic             deq,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wmask,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_resp,
    output logic             cdb_valid,
    output logic [31:0]      cdb_value,
    output logic [ROB_W-1:0] cdb_dest_rob,
    output logic             cdb_st
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    logic [ROB_W-1:0] dest_q, dest_d;
    logic             squash_q, squash_d;

    logic             deq_q, deq_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_wmask_q, mem_wmask_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [31:0]      cdb_value_q, cdb_value_d;
    logic [ROB_W-1:0] cdb_dest_q, cdb_dest_d;
    logic             cdb_st_q, cdb_st_d;

    logic launch_rd, launch_wr;

    function automatic logic [31:0] load_extend(input logic [31:0] data,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            3'b000:  return {4{wdata[7:0]}};
            3'b001:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Stores wait until they are the oldest ROB entry so they never write speculatively.
    assign launch_rd = head_valid & ~head_st & head_addr_valid & ~flush;
    assign launch_wr = head_valid & head_st & head_addr_valid & head_wdata_valid
                     & (head_dest_rob == rob_head) & ~flush;

    // NOTE: every registered signal uses <= so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            off_q       <= '0;
            dest_q      <= '0;
            squash_q    <= 1'b0;
            deq_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
            cdb_valid_q <= 1'b0;
            cdb_value_q <= '0;
            cdb_dest_q  <= '0;
            cdb_st_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            dest_q      <= dest_d;
            squash_q    <= squash_d;
            deq_q       <= deq_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_value_q <= cdb_value_d;
            cdb_dest_q  <= cdb_dest_d;
            cdb_st_q    <= cdb_st_d;
        end
    end

    // NOTE: defaults at the top of each comb block keep every path assigned, so no latches.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        dest_d   = dest_q;
        squash_d = squash_q;
        unique case (state_q)
            IDLE: begin
                squash_d = 1'b0;
                if (launch_rd || launch_wr) begin
                    state_d  = launch_rd ? RD_WAIT : WR_WAIT;
                    funct3_d = head_funct3;
                    off_d    = head_addr[1:0];
                    dest_d   = head_dest_rob;
                end
            end
            RD_WAIT: begin
                if (flush) squash_d = 1'b1;
                if (mem_resp) begin
                    state_d  = (squash_q || flush) ? IDLE : DONE;
                    squash_d = 1'b0;
                end
            end
            WR_WAIT: if (mem_resp) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; requests are held until mem_resp.
    always_comb begin
        deq_d       = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wmask_d = '0;
        mem_wdata_d = '0;
        cdb_valid_d = 1'b0;
        cdb_value_d = '0;
        cdb_dest_d  = '0;
        cdb_st_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch_rd) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = {head_addr[31:2], 2'b00};
                end else if (launch_wr) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = {head_addr[31:2], 2'b00};
                    mem_wmask_d = store_mask(head_funct3, head_addr[1:0]);
                    mem_wdata_d = store_data(head_funct3, head_wdata);
                end
            end
            RD_WAIT: begin
                if (!mem_resp) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = mem_addr_q;
                end else if (!(squash_q || flush)) begin
                    deq_d       = 1'b1;
                    cdb_valid_d = 1'b1;
                    cdb_value_d = load_extend(mem_rdata, funct3_q, off_q);
                    cdb_dest_d  = dest_q;
                end
            end
            WR_WAIT: begin
                if (!mem_resp) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wmask_d = mem_wmask_q;
                    mem_wdata_d = mem_wdata_q;
                end else begin
                    deq_d       = 1'b1;
                    cdb_valid_d = 1'b1;
                    cdb_dest_d  = dest_q;
                    cdb_st_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign deq          = deq_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wmask    = mem_wmask_q;
    assign mem_wdata    = mem_wdata_q;
    assign cdb_valid    = cdb_valid_q;
    assign cdb_value    = cdb_value_q;
    assign cdb_dest_rob = cdb_dest_q;
    assign cdb_st       = cdb_st_q;

endmodule

// File: tb/tb_ld_st_mem_ctrl.sv
// Scoreboarded bench for ld_st_mem_ctrl: byte-lane memory reference model, random-latency
// memory responder, and a monitor that checks every CDB broadcast.
module tb_ld_st_mem_ctrl;
    localparam int ROB_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             head_valid, head_st, head_addr_valid, head_wdata_valid;
    logic [31:0]      head_addr, head_wdata;
    logic [ROB_W-1:0] head_dest_rob, rob_head;
    logic [2:0]       head_funct3;
    logic             flush;
    logic             deq, mem_read, mem_write, mem_resp;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_wmask;
    logic             cdb_valid, cdb_st;
    logic [31:0]      cdb_value;
    logic [ROB_W-1:0] cdb_dest_rob;

    ld_st_mem_ctrl #(.ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst),
        .head_valid(head_valid), .head_st(head_st), .head_addr(head_addr),
        .head_addr_valid(head_addr_valid), .head_wdata(head_wdata),
        .head_wdata_valid(head_wdata_valid), .head_dest_rob(head_dest_rob),
        .head_funct3(head_funct3), .rob_head(rob_head), .flush(flush),
        .deq(deq), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .cdb_valid(cdb_valid), .cdb_value(cdb_value),
        .cdb_dest_rob(cdb_dest_rob), .cdb_st(cdb_st)
    );

    typedef struct packed {
        logic             st;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [2:0]       f3;
        logic [ROB_W-1:0] dest;
    } op_t;

    typedef struct packed {
        logic [31:0]      value;
        logic [ROB_W-1:0] dest;
        logic             st;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tb_mem[256];
    logic [31:0] ref_mem[256];
    int          vectors = 0;
    int          miscompares = 0;
    int          lat_cfg = 0;
    int          req_cycles = 0;
    logic [3:0]  last_wmask;
    logic [31:0] last_wdata;
    bit          aborted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Reference: memory as byte lanes; loads extract and extend arithmetically.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          i;
        int          off;
        int          hs;
        logic [31:0] w, b, h;
        i   = int'(op.addr[9:2]);
        off = int'(op.addr[1:0]);
        hs  = int'(op.addr[1]);
        w   = ref_mem[i];
        e.dest = op.dest;
        e.st   = op.st;
        e.value = 32'd0;
        if (op.st) begin
            case (op.f3)
                3'd0:    w[8*off +: 8]  = op.wdata[7:0];
                3'd1:    w[16*hs +: 16] = op.wdata[15:0];
                default: w = op.wdata;
            endcase
            ref_mem[i] = w;
        end else begin
            b = (w >> (8 * off)) & 32'hFF;
            h = (w >> (16 * hs)) & 32'hFFFF;
            case (op.f3)
                3'd0:    e.value = (b >= 32'd128)   ? b - 32'd256   : b;
                3'd1:    e.value = (h >= 32'd32768) ? h - 32'd65536 : h;
                3'd4:    e.value = b;
                3'd5:    e.value = h;
                default: e.value = w;
            endcase
        end
        return e;
    endfunction

    function automatic op_t mk(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic [ROB_W-1:0] dest);
        op_t o;
        o.st = st; o.addr = addr; o.wdata = wdata; o.f3 = f3; o.dest = dest;
        return o;
    endfunction

    // Memory responder: fixed or random latency, one-cycle mem_resp.
    initial begin : responder
        bit          busy;
        int          cnt;
        logic [31:0] req_addr, w;
        busy = 0; cnt = 0; req_addr = 0;
        mem_resp = 1'b0;
        mem_rdata = $urandom;
        forever begin
            @(negedge clk);
            mem_rdata = $urandom;
            if (!rst) begin
                mem_resp = 1'b0;
                busy = 0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
                busy = 0;
            end else if (mem_read || mem_write) begin
                req_cycles++;
                if (!busy) begin
                    busy = 1;
                    cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
                    req_addr = mem_addr;
                end else begin
                    check("req_addr_stable", mem_addr, req_addr);
                end
                if (cnt == 0) begin
                    mem_resp = 1'b1;
                    if (mem_write) begin
                        w = tb_mem[mem_addr[9:2]];
                        for (int k = 0; k < 4; k++)
                            if (mem_wmask[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
                        tb_mem[mem_addr[9:2]] = w;
                    end else begin
                        mem_rdata = tb_mem[mem_addr[9:2]];
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every CDB broadcast.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (cdb_valid || deq)
                    check("deq_with_cdb_valid", 32'(deq), 32'(cdb_valid));
                if (cdb_valid) begin
                    if (sb.size() == 0) begin
                        fail_now($sformatf("unexpected_cdb value=%h dest=%0d", cdb_value, cdb_dest_rob));
                    end else begin
                        e = sb.pop_front();
                        check("cdb_value", cdb_value, e.value);
                        check("cdb_dest_rob", 32'(cdb_dest_rob), 32'(e.dest));
                        check("cdb_st", 32'(cdb_st), 32'(e.st));
                    end
                end
                if (mem_read || mem_write) begin
                    check("addr_aligned", 32'(mem_addr[1:0]), 32'd0);
                    check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
                end
                if (mem_read) check("rd_wmask_zero", 32'(mem_wmask), 32'd0);
            end
        end
    end

    task automatic run_op(input op_t op, input bit scramble, input bit store_flush,
                          input int d_addr, input int d_wdata, input int d_rob);
        bit launched, done;
        sb.push_back(model(op));
        req_cycles = 0;
        head_valid = 1'b1;
        head_st = op.st;
        head_addr = op.addr;
        head_wdata = op.wdata;
        head_funct3 = op.f3;
        head_dest_rob = op.dest;
        head_addr_valid = (d_addr == 0);
        head_wdata_valid = (d_wdata == 0);
        rob_head = op.st ? ((d_rob == 0) ? op.dest : op.dest - 1'b1) : ROB_W'($urandom);
        launched = 0;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (deq) begin
                done = 1;
            end else if (mem_read || mem_write) begin
                if (!launched) begin
                    check("launch_kind_st", 32'(mem_write), 32'(op.st));
                    check("launch_addr_valid", 32'(head_addr_valid), 32'd1);
                    if (op.st) begin
                        check("store_nonspec_rob", 32'(rob_head), 32'(op.dest));
                        check("store_wdata_valid", 32'(head_wdata_valid), 32'd1);
                        last_wmask = mem_wmask;
                        last_wdata = mem_wdata;
                    end
                end
                launched = 1;
                if (scramble) begin
                    head_addr = $urandom;
                    head_wdata = $urandom;
                    head_funct3 = 3'($urandom);
                    head_dest_rob = ROB_W'($urandom);
                    rob_head = ROB_W'($urandom);
                    head_st = 1'($urandom);
                end
                if (op.st && store_flush) flush = 1'($urandom);
            end else if (!launched) begin
                head_addr_valid = (c + 1 >= d_addr);
                head_wdata_valid = (c + 1 >= d_wdata);
                if (op.st && c + 1 >= d_rob) rob_head = op.dest;
            end
        end
        if (!done) begin
            fail_now("op_timeout waiting for deq");
            aborted = 1;
        end
        if (op.st && store_flush) flush = 1'($urandom);
        head_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_read(output bit ok);
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (mem_read) ok = 1;
        end
        if (!ok) fail_now("timeout waiting for mem_read");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        bit   ok;
        op_t  op;
        logic [31:0] w;
        rst = 1'b0;
        head_valid = 0; head_st = 0; head_addr = 0; head_addr_valid = 0;
        head_wdata = 0; head_wdata_valid = 0; head_dest_rob = 0; head_funct3 = 0;
        rob_head = 0; flush = 0;
        last_wmask = 0; last_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            tb_mem[i] = w;
            ref_mem[i] = w;
        end
        #1;
        check("reset_outputs_zero",
              32'(|{deq, mem_read, mem_write, mem_addr, mem_wmask, mem_wdata,
                    cdb_valid, cdb_value, cdb_dest_rob, cdb_st}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // LW with single-cycle memory
        tb_mem[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
        lat_cfg = 0;
        run_op(mk(0, 32'h100, 0, 3'b010, 5'd3), 0, 0, 0, 0, 0);
        check("lw_read_cycles", 32'(req_cycles), 32'd1);

        // Sub-word loads
        tb_mem[8'h40] = 32'h80FFFF00; ref_mem[8'h40] = 32'h80FFFF00;
        run_op(mk(0, 32'h103, 0, 3'b000, 5'd4), 0, 0, 0, 0, 0);
        run_op(mk(0, 32'h103, 0, 3'b100, 5'd5), 0, 0, 0, 0, 0);
        run_op(mk(0, 32'h102, 0, 3'b001, 5'd6), 0, 0, 0, 0, 0);

        // SH waits for rob_head to reach its dest
        run_op(mk(1, 32'h202, 32'h00001234, 3'b001, 5'd7), 0, 0, 0, 0, 4);
        check("sh_wmask", 32'(last_wmask), 32'h0000000C);
        check("sh_wdata", last_wdata, 32'h12341234);
        run_op(mk(0, 32'h200, 0, 3'b010, 5'd8), 0, 0, 0, 0, 0);

        // flush with a ready launch in IDLE holds the controller idle
        op = mk(0, 32'h0C4, 0, 3'b010, 5'd10);
        head_valid = 1; head_st = 0; head_addr = op.addr; head_addr_valid = 1;
        head_funct3 = op.f3; head_dest_rob = op.dest; flush = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("flush_blocks_launch", 32'(mem_read), 32'd0);
        end
        flush = 0;
        run_op(op, 0, 0, 0, 0, 0);

        // flush during a 4-cycle load: request held, no broadcast
        lat_cfg = 3;
        req_cycles = 0;
        head_valid = 1; head_st = 0; head_addr = 32'h300; head_addr_valid = 1;
        head_funct3 = 3'b010; head_dest_rob = 5'd9;
        wait_read(ok);
        @(negedge clk);
        flush = 1; head_valid = 0;
        @(negedge clk);
        flush = 0;
        for (int c = 0; c < 20 && mem_read; c++) @(negedge clk);
        check("squash_read_cycles", 32'(req_cycles), 32'd4);
        for (int c = 0; c < 4; c++) begin
            check("squash_no_deq", 32'(deq), 32'd0);
            @(negedge clk);
        end
        lat_cfg = 0;
        run_op(mk(0, 32'h304, 0, 3'b010, 5'd11), 0, 0, 0, 0, 0);

        // reset during RD_WAIT abandons the access
        lat_cfg = 5;
        head_valid = 1; head_st = 0; head_addr = 32'h2F0; head_addr_valid = 1;
        head_funct3 = 3'b010; head_dest_rob = 5'd12;
        wait_read(ok);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("reset_drops_read", 32'(mem_read), 32'd0);
        check("reset_no_cdb", 32'(cdb_valid | deq), 32'd0);
        head_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lat_cfg = 0;
        run_op(mk(0, 32'h2F0, 0, 3'b010, 5'd12), 0, 0, 0, 0, 0);

        // Random mix
        lat_cfg = -1;
        for (int n = 0; n < 150 && !aborted; n++) begin
            op.st = ($urandom_range(0, 9) < 4);
            op.addr = 32'($urandom_range(0, 1023));
            op.wdata = $urandom;
            op.dest = ROB_W'($urandom);
            if (op.st) op.f3 = 3'($urandom_range(0, 2));
            else       op.f3 = 3'($urandom_range(0, 7));
            run_op(op, 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
